// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state TMS-driven FSM with IR/DR control strobes.
// Optional TapState [3:0] state-code output when TAP_STATE_OUT_EN is defined.
module tap_controller (
  input  logic       TCLK,
  input  logic       RstBar,
  input  logic       TMS,
  output logic       ShiftIR,
  output logic       ClockIR,
  output logic       UpdateIR,
  output logic       ShiftDR,
  output logic       ClockDR,
  output logic       UpdateDR,
  output logic       Select,
  output logic       Enable,
  output logic       TapRstBar
`ifdef TAP_STATE_OUT_EN
  ,
  output logic [3:0] TapState
`endif
);

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  tap_state_e state, nxt_state;

  always_ff @(posedge TCLK or negedge RstBar) begin
    if (!RstBar) state <= TLR;
    else         state <= nxt_state;
  end

  always_comb begin
    nxt_state = TLR;
    case (state)
      TLR:      nxt_state = TMS ? TLR    : RTI;
      RTI:      nxt_state = TMS ? SEL_DR : RTI;
      SEL_DR:   nxt_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   nxt_state = TMS ? EX1_DR : SH_DR;
      SH_DR:    nxt_state = TMS ? EX1_DR : SH_DR;
      EX1_DR:   nxt_state = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: nxt_state = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   nxt_state = TMS ? UPD_DR : SH_DR;
      UPD_DR:   nxt_state = TMS ? SEL_DR : RTI;
      SEL_IR:   nxt_state = TMS ? TLR    : CAP_IR;
      CAP_IR:   nxt_state = TMS ? EX1_IR : SH_IR;
      SH_IR:    nxt_state = TMS ? EX1_IR : SH_IR;
      EX1_IR:   nxt_state = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: nxt_state = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   nxt_state = TMS ? UPD_IR : SH_IR;
      UPD_IR:   nxt_state = TMS ? SEL_DR : RTI;
      default:  nxt_state = TLR;
    endcase
  end

  // Strobes decoded straight from state so they are valid for the whole cycle.
  always_comb begin
    ClockIR  = 1'b1;
    ClockDR  = 1'b1;
    UpdateIR = 1'b0;
    UpdateDR = 1'b0;
    Select   = 1'b0;
    case (state)
      CAP_IR, SH_IR: begin
        ClockIR = 1'b0;
        Select  = 1'b1;
      end
      UPD_IR: begin
        UpdateIR = 1'b1;
        Select   = 1'b1;
      end
      SEL_IR, EX1_IR, PAUSE_IR, EX2_IR: Select = 1'b1;
      CAP_DR, SH_DR:                    ClockDR = 1'b0;
      UPD_DR:                           UpdateDR = 1'b1;
      default: ;
    endcase
  end

  // Falling-edge copies keep shift select and TDO enable stable across the next rising edge.
  always_ff @(negedge TCLK or negedge RstBar) begin
    if (!RstBar) begin
      ShiftIR   <= 1'b0;
      ShiftDR   <= 1'b0;
      Enable    <= 1'b0;
      TapRstBar <= 1'b0;
    end else begin
      ShiftIR   <= (state == SH_IR);
      ShiftDR   <= (state == SH_DR);
      Enable    <= (state == SH_IR) || (state == SH_DR);
      TapRstBar <= (state != TLR);
    end
  end

`ifdef TAP_STATE_OUT_EN
  assign TapState = state;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Randomized bench for tap_controller against a phase/column reference model,
// with a 3-bit instruction register hung off the IR strobes.
module tb_tap_controller;
  logic TCLK = 1'b0, RstBar = 1'b1, TMS = 1'b1, tdi = 1'b0;
  logic ShiftIR, ClockIR, UpdateIR, ShiftDR, ClockDR, UpdateDR, Select, Enable, TapRstBar;
`ifdef TAP_STATE_OUT_EN
  logic [3:0] TapState;
`endif

  int n_chk = 0, n_err = 0;

  tap_controller dut (
    .TCLK(TCLK), .RstBar(RstBar), .TMS(TMS),
    .ShiftIR(ShiftIR), .ClockIR(ClockIR), .UpdateIR(UpdateIR),
    .ShiftDR(ShiftDR), .ClockDR(ClockDR), .UpdateDR(UpdateDR),
    .Select(Select), .Enable(Enable), .TapRstBar(TapRstBar)
`ifdef TAP_STATE_OUT_EN
    , .TapState(TapState)
`endif
  );

  always #5 TCLK = ~TCLK;

  // 3-bit IR driven by the controller strobes; capture value 3'b001.
  logic [2:0] ir_sr = 3'b000, ir_dout = 3'b000;
  always @(posedge TCLK) if (!ClockIR) ir_sr <= ShiftIR ? {tdi, ir_sr[2:1]} : 3'b001;
  always @(negedge TCLK) if (UpdateIR) ir_dout <= ir_sr;

  // Reference model: a phase plus a column flag (IR vs DR).
  typedef enum int {P_TLR, P_RTI, P_SEL, P_CAP, P_SH, P_EX1, P_PAUSE, P_EX2, P_UPD} phase_e;
  phase_e m_ph = P_TLR;
  bit m_ir = 1'b0;
  logic [2:0] m_sr = 3'b000, m_dout = 3'b000;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_advance(input bit t);
    if (m_ir && m_ph == P_CAP) m_sr = 3'b001;
    if (m_ir && m_ph == P_SH)  m_sr = {tdi, m_sr[2:1]};
    case (m_ph)
      P_TLR:   m_ph = t ? P_TLR : P_RTI;
      P_RTI:   begin m_ph = t ? P_SEL : P_RTI; m_ir = 1'b0; end
      P_SEL:   if (t) begin
                 if (m_ir) begin m_ph = P_TLR; m_ir = 1'b0; end
                 else m_ir = 1'b1;
               end else m_ph = P_CAP;
      P_CAP, P_SH: m_ph = t ? P_EX1 : P_SH;
      P_EX1:   m_ph = t ? P_UPD : P_PAUSE;
      P_PAUSE: m_ph = t ? P_EX2 : P_PAUSE;
      P_EX2:   m_ph = t ? P_UPD : P_SH;
      P_UPD:   begin m_ph = t ? P_SEL : P_RTI; m_ir = 1'b0; end
      default: m_ph = P_TLR;
    endcase
  endtask

  function automatic logic [3:0] m_code();
    case (m_ph)
      P_TLR:   return 4'hF;
      P_RTI:   return 4'hC;
      P_SEL:   return m_ir ? 4'h4 : 4'h7;
      P_CAP:   return m_ir ? 4'hE : 4'h6;
      P_SH:    return m_ir ? 4'hA : 4'h2;
      P_EX1:   return m_ir ? 4'h9 : 4'h1;
      P_PAUSE: return m_ir ? 4'hB : 4'h3;
      P_EX2:   return m_ir ? 4'h8 : 4'h0;
      default: return m_ir ? 4'hD : 4'h5;
    endcase
  endfunction

  task automatic check_comb();
    bit shc = (m_ph == P_CAP) || (m_ph == P_SH);
    chk("ClockIR",  {3'b0, ClockIR},  {3'b0, !(m_ir && shc)});
    chk("ClockDR",  {3'b0, ClockDR},  {3'b0, !(!m_ir && shc)});
    chk("UpdateIR", {3'b0, UpdateIR}, {3'b0, m_ir && m_ph == P_UPD});
    chk("UpdateDR", {3'b0, UpdateDR}, {3'b0, !m_ir && m_ph == P_UPD});
    chk("Select",   {3'b0, Select},   {3'b0, m_ir});
`ifdef TAP_STATE_OUT_EN
    chk("TapState", TapState, m_code());
`endif
  endtask

  task automatic check_reg();
    chk("ShiftIR",   {3'b0, ShiftIR},   {3'b0, m_ir && m_ph == P_SH});
    chk("ShiftDR",   {3'b0, ShiftDR},   {3'b0, !m_ir && m_ph == P_SH});
    chk("Enable",    {3'b0, Enable},    {3'b0, m_ph == P_SH});
    chk("TapRstBar", {3'b0, TapRstBar}, {3'b0, m_ph != P_TLR});
    chk("ir_dout",   {1'b0, ir_dout},   {1'b0, m_dout});
  endtask

  // One TCLK cycle: drive, check strobes after rise, check registered outputs after fall.
  task automatic step(input bit t, input bit d);
    TMS = t; tdi = d;
    @(posedge TCLK);
    m_advance(t);
    #1 check_comb();
    @(negedge TCLK);
    if (m_ir && m_ph == P_UPD) m_dout = m_sr;
    #1 check_reg();
  endtask

  // Reset asserted between edges; outputs must fall back immediately.
  task automatic async_reset();
    RstBar = 1'b0;
    m_ph = P_TLR; m_ir = 1'b0;
    #1 check_comb(); check_reg();
    TMS = 1'($urandom);
    @(posedge TCLK);
    #1 check_comb(); check_reg();
    @(negedge TCLK);
    #1 check_reg();
    #2 RstBar = 1'b1;
  endtask

  task automatic walk(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte b = s[i];
      step(b == "1", 1'($urandom));
    end
  endtask

  string paths[16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101", "01011",
                       "011", "0110", "01100", "01101", "011010", "0110101", "011011"};

  initial begin
    #1 async_reset();
    // IR capture, shift 1,0,1, update
    walk("01100");
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("ir_101", {1'b0, ir_dout}, 4'h5);
    // DR path through Pause
    walk("1001010110");
    // five TMS=1 edges from every state
    for (int p = 0; p < 16; p++) begin
      walk("11111");
      walk(paths[p]);
      walk("11111");
      chk("tlr_rst", {3'b0, TapRstBar}, 4'h0);
    end
    // reset mid-shift in ShDR
    async_reset();
    walk("0100");
    walk("00");
    async_reset();
    step(1'b0, 1'b0);
    // random walk with occasional reset and reset bursts
    for (int n = 0; n < 1500; n++) begin
      int r = $urandom_range(0, 99);
      if (r == 0) async_reset();
      else if (r < 4) walk("11111");
      else step($urandom_range(0, 2) == 0, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
